// File: rtl/tick_timer_if.sv
// Control/status bundle between a tick_timer and whatever drives it.
// The master modport drives the controls; the slave modport is the timer itself.
interface tick_timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             tick;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cmp_val;
  logic             irq_clr;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             irq;
  logic             pwm_out;

  modport master (
    output tick, start, stop, pause, auto_reload, load_val, cmp_val, irq_clr,
    input  count, busy, done, irq, pwm_out
  );

  modport slave (
    input  tick, start, stop, pause, auto_reload, load_val, cmp_val, irq_clr,
    output count, busy, done, irq, pwm_out
  );
endinterface

// File: rtl/tick_timer.sv
// Prescaled down-counting timer with one-shot/auto-reload modes, pause/stop,
// a sticky interrupt flag and a compare-based PWM output.
module tick_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  tick_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q,  done_d;
  logic             irq_q,   irq_d;
  logic             start_ok;

  assign start_ok = bus.start && (bus.load_val != WIDTH'(0));

  // Next-state logic; priority is stop > start > pause > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    irq_d   = irq_q;

    if (bus.irq_clr) begin
      irq_d = 1'b0;
    end

    if (bus.stop) begin
      state_d = IDLE;
      count_d = WIDTH'(0);
    end else if (start_ok) begin
      state_d = RUN;
      count_d = bus.load_val;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.pause) begin
            state_d = HOLD;
          end else if (bus.tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Expiry: irq set overrides a coincident irq_clr.
              done_d = 1'b1;
              irq_d  = 1'b1;
              if (bus.auto_reload && (bus.load_val != WIDTH'(0))) begin
                count_d = bus.load_val;
              end else begin
                count_d = WIDTH'(0);
                state_d = IDLE;
              end
            end
          end
        end
        HOLD: begin
          if (!bus.pause) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= WIDTH'(0);
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.irq     = irq_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.pwm_out = (state_q != IDLE) && (count_q <= bus.cmp_val);

endmodule

// File: tb/tb_tick_timer.sv
// Table-driven bench for tick_timer: each vector's expected outputs go through
// a scoreboard queue and are compared one clock after the inputs are applied.
module tb_tick_timer;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tick_timer_if #(.WIDTH(W)) bus ();
  tick_timer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic rst, tk, st, sp, ps, ar, clr;
    logic [W-1:0] ld, cmp;
    logic [W-1:0] cnt;
    logic busy, done, irq, pwm;
  } vec_t;

  typedef logic [W+3:0] obs_t;

  vec_t tbl[$];
  obs_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(input logic rst, tk, st, sp, ps, ar,
                              input logic [W-1:0] ld, cmp, input logic clr,
                              input logic [W-1:0] cnt,
                              input logic busy, done, irq, pwm);
    vec_t v;
    v.rst = rst; v.tk = tk; v.st = st; v.sp = sp; v.ps = ps; v.ar = ar;
    v.ld = ld; v.cmp = cmp; v.clr = clr;
    v.cnt = cnt; v.busy = busy; v.done = done; v.irq = irq; v.pwm = pwm;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Drive one vector, queue its expectation, compare just after the edge.
  task automatic step(input vec_t v, input string name);
    obs_t act, e;
    reset = v.rst; bus.tick = v.tk; bus.start = v.st; bus.stop = v.sp;
    bus.pause = v.ps; bus.auto_reload = v.ar; bus.load_val = v.ld;
    bus.cmp_val = v.cmp; bus.irq_clr = v.clr;
    exp_q.push_back({v.cnt, v.busy, v.done, v.irq, v.pwm});
    @(posedge clk); #1;
    act = {bus.count, bus.busy, bus.done, bus.irq, bus.pwm_out};
    e = exp_q.pop_front();
    total++;
    if (act === e) passed++;
    else $display("FAIL %s: got cnt=%0d busy=%0b done=%0b irq=%0b pwm=%0b, required cnt=%0d busy=%0b done=%0b irq=%0b pwm=%0b",
                  name, act[W+3:4], act[3], act[2], act[1], act[0],
                  e[W+3:4], e[3], e[2], e[1], e[0]);
  endtask

  initial begin
    int ticks;
    bit seen;
    reset = 1'b1; bus.tick = 0; bus.start = 0; bus.stop = 0; bus.pause = 0;
    bus.auto_reload = 0; bus.load_val = '0; bus.cmp_val = '0; bus.irq_clr = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset, then start with load_val 0 is ignored
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0, 0,0,0,0,0));
    // one-shot, load 3, tick every 4th clk
    tbl.push_back(mk(0,0,1,0,0,0, 3,0,0, 3,1,0,0,0));
    for (int n = 3; n >= 2; n--) begin
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0,0,0,0, 3,0,0, W'(n),1,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 3,0,0, W'(n-1),1,0,0,0));
    end
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0,0,0,0, 3,0,0, 1,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 3,0,0, 0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 3,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 3,0,1, 0,0,0,0,0));
    // auto-reload load 2, tick every clk, auto_reload dropped for the 4th expiry
    tbl.push_back(mk(0,0,1,0,0,1, 2,0,0, 2,1,0,0,0));
    for (int p = 0; p < 4; p++) begin
      tbl.push_back(mk(0,1,0,0,0,1, 2,0,0, 1,1,0,(p > 0),0));
      if (p < 3) tbl.push_back(mk(0,1,0,0,0,1, 2,0,0, 2,1,1,1,0));
      else       tbl.push_back(mk(0,1,0,0,0,0, 2,0,0, 0,0,1,1,0));
    end
    tbl.push_back(mk(0,1,0,0,0,0, 2,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 2,0,1, 0,0,0,0,0));
    // stop wins over a coincident start; irq_clr coincident with expiry
    tbl.push_back(mk(0,0,1,0,0,0, 7,0,0, 7,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 7,0,0, 6,1,0,0,0));
    tbl.push_back(mk(0,1,1,1,0,0, 7,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 7,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 1,0,0, 1,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,1, 0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,1, 0,0,0,0,0));
    // PWM: load 4 cmp 2, then cmp 0; stop leaves irq set
    tbl.push_back(mk(0,0,1,0,0,1, 4,2,0, 4,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 4,2,0, 3,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 4,2,0, 2,1,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,1, 4,2,0, 1,1,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,1, 4,2,0, 4,1,1,1,0));
    tbl.push_back(mk(0,1,0,0,0,1, 4,2,0, 3,1,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,1, 4,0,0, 2,1,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,1, 4,0,0, 1,1,0,1,0));
    tbl.push_back(mk(0,0,0,1,0,1, 4,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 4,0,1, 0,0,0,0,0));
    // cmp above load keeps pwm high for the whole run
    tbl.push_back(mk(0,0,1,0,0,0, 3,5,0, 3,1,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0, 3,5,0, 2,1,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0, 3,5,0, 1,1,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0, 3,5,0, 0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 3,5,1, 0,0,0,0,0));
    // reset mid-run with irq set, reset over start, start with load 0
    tbl.push_back(mk(0,0,1,0,0,0, 1,0,0, 1,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,0, 0,0,1,1,0));
    tbl.push_back(mk(0,0,1,0,0,0, 6,0,0, 6,1,0,1,0));
    tbl.push_back(mk(1,1,0,0,0,0, 6,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,0,0, 5,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0, 0,0,0,0,0));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Pause sequence: load 10, 5 ticks, 10 paused ticks, then exactly 5 more to done.
    step(mk(0,0,1,0,0,0, 10,0,0, 10,1,0,0,0), "pause_start");
    for (int k = 1; k <= 5; k++)
      step(mk(0,1,0,0,0,0, 10,0,0, W'(10-k),1,0,0,0), $sformatf("pause_run%0d", k));
    for (int k = 0; k < 10; k++)
      step(mk(0,1,0,0,1,0, 10,0,0, 5,1,0,0,0), $sformatf("pause_hold%0d", k));
    step(mk(0,1,0,0,0,0, 10,0,0, 5,1,0,0,0), "pause_release");

    ticks = 0;
    seen  = 1'b0;
    bus.tick = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      ticks++;
      seen = bus.done;
    end
    bus.tick = 1'b0;
    check("pause_done_seen", int'(seen), 1);
    check("pause_ticks_to_done", ticks, 5);
    check("pause_final_count", int'(bus.count), 0);
    check("pause_final_busy", int'(bus.busy), 0);
    check("pause_final_irq", int'(bus.irq), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
